// File: rtl/hcordic_pkg.sv
// ---------------------------------------------------------------------------
// hcordic_pkg
// Shared constants and types for the HCORDIC datapath stages.
//   - mode and idle encodings
//   - zout field positions {sign[35], exp[34:27], mant[26:0]}
//   - exponent value that marks a zero result
//   - sideband bundle that travels alongside a word through a stage
// ---------------------------------------------------------------------------
package hcordic_pkg;

    localparam int PROD_W = 50;
    localparam int MANT_W = 27;
    localparam int Z_W    = 36;

    localparam logic [1:0] MODE_LINEAR     = 2'b00;
    localparam logic [1:0] MODE_CIRCULAR   = 2'b01;
    localparam logic [1:0] MODE_HYPERBOLIC = 2'b11;

    localparam logic [1:0] IDLE_NO     = 2'b00;
    localparam logic [1:0] IDLE_ALLIGN = 2'b01;
    localparam logic [1:0] IDLE_PUT    = 2'b10;

    localparam int Z_SIGN    = 35;
    localparam int Z_EXP_HI  = 34;
    localparam int Z_EXP_LO  = 27;
    localparam int Z_MANT_HI = 26;

    localparam logic [7:0] EXP_ZERO = 8'h80;

    // Fields copied unmodified from stage to stage.
    typedef struct packed {
        logic [35:0] cout;
        logic [31:0] sout;
        logic [1:0]  mode;
        logic        operation;
        logic        natlog;
        logic [7:0]  tag;
    } sideband_t;

endpackage

// File: rtl/normalise_product_if.sv
// ---------------------------------------------------------------------------
// normalise_product_if
// Bundle of the words entering (from the multiply stage) and leaving the
// normalise-product stage.
// Handshake: there is no ready. A word is taken on every rising clock edge
// where the shared enable is high; valid_* marks whether that word carries
// data. The producer must stall with the same enable.
// Modports:
//   master : upstream/test side, drives *_Multiply, observes *_NormaliseProd
//   slave  : the stage itself, reads *_Multiply, drives *_NormaliseProd
// ---------------------------------------------------------------------------
interface normalise_product_if;

    logic        valid_Multiply;
    logic [1:0]  idle_Multiply;
    logic [35:0] zout_Multiply;
    logic [49:0] productout_Multiply;
    logic [35:0] cout_Multiply;
    logic [31:0] sout_Multiply;
    logic [1:0]  modeout_Multiply;
    logic        operationout_Multiply;
    logic        NatLogFlagout_Multiply;
    logic [7:0]  InsTag_Multiply;

    logic        valid_NormaliseProd;
    logic [1:0]  idle_NormaliseProd;
    logic [35:0] zout_NormaliseProd;
    logic [35:0] cout_NormaliseProd;
    logic [31:0] sout_NormaliseProd;
    logic [1:0]  modeout_NormaliseProd;
    logic        operationout_NormaliseProd;
    logic        NatLogFlagout_NormaliseProd;
    logic [7:0]  InsTag_NormaliseProd;

    modport master (
        output valid_Multiply, idle_Multiply, zout_Multiply, productout_Multiply,
               cout_Multiply, sout_Multiply, modeout_Multiply, operationout_Multiply,
               NatLogFlagout_Multiply, InsTag_Multiply,
        input  valid_NormaliseProd, idle_NormaliseProd, zout_NormaliseProd,
               cout_NormaliseProd, sout_NormaliseProd, modeout_NormaliseProd,
               operationout_NormaliseProd, NatLogFlagout_NormaliseProd,
               InsTag_NormaliseProd
    );

    modport slave (
        input  valid_Multiply, idle_Multiply, zout_Multiply, productout_Multiply,
               cout_Multiply, sout_Multiply, modeout_Multiply, operationout_Multiply,
               NatLogFlagout_Multiply, InsTag_Multiply,
        output valid_NormaliseProd, idle_NormaliseProd, zout_NormaliseProd,
               cout_NormaliseProd, sout_NormaliseProd, modeout_NormaliseProd,
               operationout_NormaliseProd, NatLogFlagout_NormaliseProd,
               InsTag_NormaliseProd
    );

endinterface

// File: rtl/lzc50.sv
// ---------------------------------------------------------------------------
// lzc50
// Combinational leading-zero counter for a 50-bit word.
// Ports:
//   i_data  [49:0] word to scan (MSB first)
//   o_count [5:0]  number of zeros above the first set bit; 50 when all zero
//   o_zero         high when i_data is all zero
// ---------------------------------------------------------------------------
module lzc50 (
    input  logic [49:0] i_data,
    output logic [5:0]  o_count,
    output logic        o_zero
);

    logic w_found;

    always_comb begin
        o_count = 6'd50;
        w_found = 1'b0;
        for (int i = 49; i >= 0; i--) begin
            if (!w_found && i_data[i]) begin
                o_count = 6'(49 - i);
                w_found = 1'b1;
            end
        end
    end

    assign o_zero = ~|i_data;

endmodule

// File: rtl/normalise_product.sv
// ---------------------------------------------------------------------------
// normalise_product
// Two-register-stage normaliser that follows the HCORDIC multiply stage.
// Stage 1 registers the incoming word plus the leading-zero count and zero
// flag of the product. Stage 2 left-aligns the product, folds the dropped
// low bits into a sticky LSB, corrects the exponent and writes the result
// into the mantissa/exponent fields of zout. Words whose idle code is not
// no_idle pass zout through untouched.
// Ports:
//   clock   rising-edge clock
//   reset   synchronous active-high clear of every register
//   enable  advance both stages; low holds everything
//   bus     slave side of normalise_product_if (inputs *_Multiply,
//           outputs *_NormaliseProd)
// ---------------------------------------------------------------------------
module normalise_product
    import hcordic_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    normalise_product_if.slave  bus
);

    // Stage 1 registers
    logic        r_s1_valid;
    logic [1:0]  r_s1_idle;
    logic [35:0] r_s1_zout;
    logic [49:0] r_s1_prod;
    logic [5:0]  r_s1_lz;
    logic        r_s1_pzero;
    sideband_t   r_s1_sb;

    // Stage 2 registers (drive the outputs)
    logic        r_s2_valid;
    logic [1:0]  r_s2_idle;
    logic [35:0] r_s2_zout;
    sideband_t   r_s2_sb;

    logic [5:0]  w_lz;
    logic        w_pzero;
    sideband_t   w_in_sb;
    logic [49:0] w_shifted;
    logic [26:0] w_mant;
    logic [7:0]  w_exp;
    logic [35:0] w_zout;

    lzc50 u_lzc (
        .i_data  (bus.productout_Multiply),
        .o_count (w_lz),
        .o_zero  (w_pzero)
    );

    assign w_in_sb = '{
        cout:      bus.cout_Multiply,
        sout:      bus.sout_Multiply,
        mode:      bus.modeout_Multiply,
        operation: bus.operationout_Multiply,
        natlog:    bus.NatLogFlagout_Multiply,
        tag:       bus.InsTag_Multiply
    };

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_idle  <= 2'b00;
            r_s1_zout  <= '0;
            r_s1_prod  <= '0;
            r_s1_lz    <= '0;
            r_s1_pzero <= 1'b0;
            r_s1_sb    <= '0;
        end else if (enable) begin
            r_s1_valid <= bus.valid_Multiply;
            r_s1_idle  <= bus.idle_Multiply;
            r_s1_zout  <= bus.zout_Multiply;
            r_s1_prod  <= bus.productout_Multiply;
            r_s1_lz    <= w_lz;
            r_s1_pzero <= w_pzero;
            r_s1_sb    <= w_in_sb;
        end
    end

    // Normalisation. The shift count never exceeds 49 for a non-zero product,
    // so the leading one always lands in bit 49. The exponent subtract wraps
    // modulo 256 on purpose; there is no underflow handling at this stage.
    always_comb begin
        w_shifted = r_s1_prod << r_s1_lz;
        w_mant    = {w_shifted[49:24], w_shifted[23] | (|w_shifted[22:0])};
        w_exp     = r_s1_zout[Z_EXP_HI:Z_EXP_LO] - {2'b00, r_s1_lz};
        w_zout    = r_s1_zout;
        if (r_s1_idle == IDLE_NO) begin
            if (r_s1_pzero) begin
                w_zout = {r_s1_zout[Z_SIGN], EXP_ZERO, {MANT_W{1'b0}}};
            end else begin
                w_zout = {r_s1_zout[Z_SIGN], w_exp, w_mant};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_idle  <= 2'b00;
            r_s2_zout  <= '0;
            r_s2_sb    <= '0;
        end else if (enable) begin
            r_s2_valid <= r_s1_valid;
            r_s2_idle  <= r_s1_idle;
            r_s2_zout  <= w_zout;
            r_s2_sb    <= r_s1_sb;
        end
    end

    assign bus.valid_NormaliseProd         = r_s2_valid;
    assign bus.idle_NormaliseProd          = r_s2_idle;
    assign bus.zout_NormaliseProd          = r_s2_zout;
    assign bus.cout_NormaliseProd          = r_s2_sb.cout;
    assign bus.sout_NormaliseProd          = r_s2_sb.sout;
    assign bus.modeout_NormaliseProd       = r_s2_sb.mode;
    assign bus.operationout_NormaliseProd  = r_s2_sb.operation;
    assign bus.NatLogFlagout_NormaliseProd = r_s2_sb.natlog;
    assign bus.InsTag_NormaliseProd        = r_s2_sb.tag;

endmodule

// File: doc/normalise_product.md
# normalise_product

Pipeline stage directly downstream of the multiply stage in the HCORDIC datapath. It takes the raw 50-bit mantissa product and the provisional `zout` word (sign and exponent already set, mantissa field zeroed). It then runs a two-stage leading-zero-count/shift normalisation and writes the normalised 27-bit mantissa, with a sticky bit, and the corrected exponent back into `zout`. All sideband fields (tag, mode, operation, idle, NatLog flag, `cout`, `sout`) travel alongside with matched latency.

## Interface
- `PROD_W`, 50, product width from the multiply stage.
- `MANT_W`, 27, mantissa field width of `zout` (bits 26:0).
- `clock`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- `enable`  in  1  pipeline advance; low = every stage register holds.
- `valid_Multiply`  in  1  input word valid.
- `idle_Multiply`  in  2  idle code: 00 no_idle, 01 allign_idle, 10 put_idle.
- `zout_Multiply`  in  36  {sign[35], exp[34:27] unbiased two's complement, mant[26:0]}.
- `productout_Multiply`  in  50  unsigned mantissa product.
- `cout_Multiply`  in  36, `sout_Multiply`  in  32, `modeout_Multiply`  in  2, `operationout_Multiply`  in  1, `NatLogFlagout_Multiply`  in  1, `InsTag_Multiply`  in  8: sidebands.
- `valid_NormaliseProd`  out  1  output valid.
- `zout_NormaliseProd`  out  36  normalised z.
- `idle_NormaliseProd`, `cout_NormaliseProd`, `sout_NormaliseProd`, `modeout_NormaliseProd`, `operationout_NormaliseProd`, `NatLogFlagout_NormaliseProd`, `InsTag_NormaliseProd`  out  matching widths: delayed sidebands.

## Operation
- Stage 1, when `enable`: register all inputs.
  - Compute `lz` = leading-zero count of the product (0..50).
  - Compute `pzero` = (product == 0).
- Stage 2, when `enable`: the result depends on the idle code and product.
- idle == no_idle, `pzero` = 0:
  - `shifted` = product << `lz` (50 bits).
  - mant = `shifted[49:23]` with bit 0 ORed with `|shifted[22:0]` (sticky).
  - exp = `zout_exp - lz`, 8-bit, wraps modulo 256, no saturation or flush.
  - sign = input sign, unchanged.
- idle == no_idle, `pzero` = 1: `zout = {sign, 8'h80, 27'h0}`. The 8'h80 exponent is the zero marker.
- idle != no_idle: `zout` passes unchanged and the product is ignored.
- Sidebands are copied stage to stage unmodified.
- `valid` shifts through the two stages with the data.
- Width rule: `lz` is 6 bits. The exponent subtract uses an 8-bit operand built from `lz[5:0]` zero-extended.

## Timing
- Latency is exactly 2 enabled cycles from input sample to output.
- Throughput is one word per enabled cycle.
- `enable` = 0: both stages hold every register, including valid. Inputs are not sampled.
- Reset: every register clears, valids go to 0, and all outputs read 0 from the following edge. Data in flight is discarded.
- `reset` and `enable` high on the same edge: reset wins.
- Invalid words, `valid_Multiply` = 0, still flow through. Their data is don't-care and the output valid is 0.
- No backpressure output. The upstream stage must gate with the same `enable`.

## Structure
- Shared package (`hcordic_pkg`):
  - mode constants: circular 01, linear 00, hyperbolic 11;
  - idle constants;
  - `zout` field positions: SIGN=35, EXP 34:27, MANT 26:0;
  - zero-exponent marker 8'h80.
- One sub-module, `lzc50`: a combinational 50-bit leading-zero counter with a 6-bit count output and an all-zero flag.
- Top level: two register stages plus the shift/sticky/exponent logic.

## Test plan
- Product 50'h2_0000_0000_0000, exp 8'h05, no_idle → after 2 cycles: mant 27'h4000000, exp 8'h05, valid 1.
- Product 50'h1_0000_0000_0000, exp 8'h05 → mant 27'h4000000, exp 8'h04.
- Product 50'h2_0000_0000_0001 → mant 27'h4000001 (sticky); exp unchanged.
- Product 0, exp 8'h10, sign 1 → zout = {1, 8'h80, 27'h0}.
- idle = put_idle, zout 36'hA_BCDE_F012, product nonzero → zout out equals 36'hA_BCDE_F012; tag and other sidebands delayed 2 cycles.
- Stall and reset sequence:
  - Feed 3 back-to-back words, then drop `enable` for 4 cycles → outputs frozen while low, order preserved on resume.
  - Assert `reset` mid-stream → next cycle all outputs 0 and valid 0.
